seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 105 ++++++++++
 tb/tb_seq_shifter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-free shifter that moves at most STEP bits
// per clock until the effective shift count is exhausted.
// Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROR (ROR only with SEQ_SHIFTER_ROTATE_EN;
// without the macro, mode 11 behaves as LSL with the count clamped to WIDTH).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, data_out holds the last result
// SHIFT | remaining down-counter > 0, shifting up to STEP bits/cycle
// DONE  | result presented on data_out until out_ready
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SAW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SAW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam int             LW      = $clog2(WIDTH);
  localparam logic [SAW-1:0] WIDTH_C = SAW'(WIDTH);
  localparam logic [SAW-1:0] STEP_C  = SAW'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic [SAW-1:0]   remaining;
  logic [1:0]       mode_r;

  logic [1:0]       mode_eff;
  logic [SAW-1:0]   cnt_eff;
  logic [SAW-1:0]   k;
  logic [WIDTH-1:0] stepped;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = data_r;

  // Request decode: effective mode and count latched on accept.
  always_comb begin
    mode_eff = mode;
    cnt_eff  = (shamt > WIDTH_C) ? WIDTH_C : shamt;
`ifdef SEQ_SHIFTER_ROTATE_EN
    if (mode == 2'b11) cnt_eff = {1'b0, shamt[LW-1:0]};
`else
    if (mode == 2'b11) mode_eff = 2'b00;
`endif
  end

  // One shift step of k = min(STEP, remaining) bits in the latched mode.
  always_comb begin
    k = (remaining > STEP_C) ? STEP_C : remaining;
    case (mode_r)
      2'b00:   stepped = data_r << k;
      2'b01:   stepped = data_r >> k;
      2'b10:   stepped = $unsigned($signed(data_r) >>> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11:   stepped = (data_r >> k) | (data_r << (WIDTH_C - k));
`endif
      default: stepped = data_r << k;
    endcase
  end

  // Sequencer: accept, step the down-counter, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_r    <= '0;
      remaining <= '0;
      mode_r    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r    <= data_in;
            mode_r    <= mode_eff;
            remaining <= cnt_eff;
            state     <= (cnt_eff == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_r    <= stepped;
          remaining <= remaining - k;
          if (remaining == k) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected results, the
// monitor pops and compares when out_valid appears.
module tb_seq_shifter;
  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int SAW  = $clog2(W) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   data_in, data_out;
  logic [SAW-1:0] shamt;
  logic [1:0]     mode;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] d;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         q[$];
  exp_t         cur;
  bit           seen       = 1'b0;
  bit           hold_ready = 1'b0;
  logic [W-1:0] last_exp   = '0;

  seq_shifter #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: bit i of the result taken from bit i -/+ count of the operand.
  function automatic exp_t model(input logic [W-1:0] d, input logic [SAW-1:0] s,
                                 input logic [1:0] m);
    exp_t       e;
    int         c;
    logic [1:0] em;
    em = m;
`ifndef SEQ_SHIFTER_ROTATE_EN
    if (em == 2'b11) em = 2'b00;
`endif
    if (em == 2'b11) c = int'(s) % W;
    else             c = (int'(s) < W) ? int'(s) : W;
    e.lat = (c + STEP - 1) / STEP;
    e.acc = 0;
    for (int i = 0; i < W; i++) begin
      case (em)
        2'b00:   e.d[i] = (i >= c)    ? d[i-c] : 1'b0;
        2'b01:   e.d[i] = (i + c < W) ? d[i+c] : 1'b0;
        2'b10:   e.d[i] = (i + c < W) ? d[i+c] : d[W-1];
        default: e.d[i] = d[(i+c)%W];
      endcase
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] d, input int lat);
    exp_t e;
    e.d   = d;
    e.lat = lat;
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [SAW-1:0] s,
                      input logic [1:0] m, input exp_t e);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = $urandom;
        shamt    = SAW'($urandom);
        mode     = 2'($urandom);
      end
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    data_in  = d;
    shamt    = s;
    mode     = m;
    @(posedge clk);
    #1;
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic rsend(input logic [W-1:0] d, input logic [SAW-1:0] s, input logic [1:0] m);
    send(d, s, m, model(d, s, m));
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: queue=%0d in_ready=%b, required 0 and 1", q.size(), in_ready);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"},  data_out,  32'h0);
    chk({tag, "_out_valid"}, out_valid, 32'h0);
    chk({tag, "_busy"},      busy,      32'h0);
    chk({tag, "_in_ready"},  in_ready,  32'h1);
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: data_out=%h with nothing pending", data_out);
            cur = mk(data_out, 0);
          end else begin
            cur = q.pop_front();
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end
        end
        chk("data_out", data_out, cur.d);
        last_exp = cur.d;
      end else begin
        seen = 1'b0;
      end
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    exp_t e;
    int   n;
    logic [W-1:0] rd;
    logic [SAW-1:0] rs;
    logic [SAW-1:0] edges[6];

    rst = 1'b1; in_valid = 1'b0; data_in = '0; shamt = '0; mode = 2'b00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed vectors with hand-derived results.
    send(32'h0000_0001, 6'd5,  2'b00, mk(32'h0000_0020, 2));
    send(32'h8000_0000, 6'd40, 2'b10, mk(32'hFFFF_FFFF, 8));
    send(32'h8000_0000, 6'd40, 2'b01, mk(32'h0000_0000, 8));
`ifdef SEQ_SHIFTER_ROTATE_EN
    send(32'h0000_00F1, 6'd36, 2'b11, mk(32'h1000_000F, 1));
`else
    send(32'h0000_00F1, 6'd36, 2'b11, mk(32'h0000_0000, 8));
`endif
    for (int m = 0; m < 4; m++)
      send(32'hDEAD_BEEF, 6'd0, 2'(m), mk(32'hDEAD_BEEF, 0));
    drain();

    // Consumer stalls for 5 cycles in DONE while new requests are offered.
    hold_ready = 1'b1;
    e = mk(32'h0246_8ACF, 1);
    send(32'h1234_5678, 6'd3, 2'b01, e);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", out_valid, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = $urandom;
      shamt    = 6'd1;
      mode     = 2'b00;
      chk("stall_out_valid", out_valid, 32'h1);
      chk("stall_in_ready",  in_ready,  32'h0);
      chk("stall_busy",      busy,      32'h1);
      chk("stall_data_out",  data_out,  e.d);
    end
    in_valid   = 1'b0;
    hold_ready = 1'b0;
    drain();

    // Reset two cycles into a long LSL discards it.
    send(32'h0000_0001, 6'd32, 2'b00, mk(32'h0, 8));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk_reset_outputs("midshift_reset");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("midshift_reset_hold");
    rst = 1'b0;
    last_exp = '0;
    repeat (10) @(negedge clk);
    chk("post_reset_out_valid", out_valid, 32'h0);
    send(32'h0000_00A5, 6'd7, 2'b00, mk(32'h0000_5280, 2));
    drain();

    // Randomized traffic checked against the reference model.
    edges = '{6'd0, 6'd1, 6'(STEP), 6'(W-1), 6'(W), 6'(2*W-1)};
    for (int t = 0; t < 150; t++) begin
      rd = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : SAW'($urandom);
      rsend(rd, rs, 2'($urandom));
    end
    drain();
    repeat (3) @(negedge clk);
    chk("idle_hold", data_out, last_exp);
    chk("idle_in_ready", in_ready, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
